// File: rtl/core.sv
// Shared core definitions: machine width, M-extension op encoding, MDU states.
package core;

  localparam int XLEN = 32;

  // RV32M funct3 encoding
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  // Divide-class ops all have funct3[2] set
  function automatic logic op_is_div(mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(mdu_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MUL only needs the low half, which is sign-agnostic, so it runs unsigned
  function automatic logic op_rs1_signed(mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rs2_signed(mdu_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the issue stage and the iterative MDU.
interface mdu_iter_if #(
  parameter int XLEN  = core::XLEN,
  parameter int TAG_W = 5
);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] rd_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] rd_o;

  modport master (
    output req_valid_i, op_i, rs1_i, rs2_i, rd_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, rd_o
  );

  modport slave (
    input  req_valid_i, op_i, rs1_i, rs2_i, rd_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, rd_o
  );

endinterface

// File: rtl/mdu_special.sv
// Detects the divide cases that bypass iteration and supplies their fixed result.
module mdu_special
  import core::*;
#(
  parameter int XLEN = core::XLEN
) (
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic div_zero;
  logic overflow;

  // Divide by zero and the single signed overflow case (most negative / -1)
  always_comb begin
    div_zero = 1'b0;
    overflow = 1'b0;
    special  = 1'b0;
    result   = '0;
    div_zero = op_is_div(op) && (rs2 == '0);
    overflow = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MOST_NEG) && (rs2 == '1);
    if (div_zero) begin
      special = 1'b1;
      result  = op_is_rem(op) ? rs1 : '1;
    end else if (overflow) begin
      special = 1'b1;
      result  = op_is_rem(op) ? '0 : MOST_NEG;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: one bit per cycle shift-add multiply and
// restoring divide over a shared 2*XLEN accumulator.
module mdu_iter
  import core::*;
#(
  parameter int XLEN  = core::XLEN,
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  output logic       busy_o,
  mdu_iter_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int AW    = XLEN + 2;

  mdu_state_t         state_q;
  mdu_state_t         state_d;
  mdu_op_t            op_q;
  mdu_op_t            op_in;
  logic [TAG_W-1:0]   rd_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [2*XLEN-1:0]  acc_iter;
  logic [XLEN-1:0]    opnd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic [XLEN-1:0]    result_q;

  logic               accept;
  logic               last_iter;
  logic               rs1_neg;
  logic               rs2_neg;
  logic               neg_in;
  logic [XLEN-1:0]    mag1;
  logic [XLEN-1:0]    mag2;
  logic               is_div;
  logic [AW-1:0]      addsub_a;
  logic [AW-1:0]      addsub_b;
  logic [AW-1:0]      addsub_y;
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    quo_fix;
  logic [XLEN-1:0]    rem_fix;
  logic [XLEN-1:0]    calc_result;
  logic               special;
  logic [XLEN-1:0]    special_result;

  assign op_in = mdu_op_t'(bus.op_i);

  mdu_special #(.XLEN(XLEN)) u_special (
    .op      (op_in),
    .rs1     (bus.rs1_i),
    .rs2     (bus.rs2_i),
    .special (special),
    .result  (special_result)
  );

  // Operand magnitudes and the sign the final result must take
  always_comb begin
    rs1_neg = op_rs1_signed(op_in) & bus.rs1_i[XLEN-1];
    rs2_neg = op_rs2_signed(op_in) & bus.rs2_i[XLEN-1];
    mag1    = rs1_neg ? -bus.rs1_i : bus.rs1_i;
    mag2    = rs2_neg ? -bus.rs2_i : bus.rs2_i;
    neg_in  = op_is_rem(op_in) ? rs1_neg : (rs1_neg ^ rs2_neg);
  end

  // One iteration step through the shared adder/subtractor
  always_comb begin
    is_div   = op_is_div(op_q);
    addsub_a = is_div ? {1'b0, acc_q[2*XLEN-1:XLEN-1]} : {2'b00, acc_q[2*XLEN-1:XLEN]};
    addsub_b = {2'b00, opnd_q} ^ {AW{is_div}};
    addsub_y = addsub_a + addsub_b + AW'(is_div);
    acc_iter = acc_q;
    if (is_div) begin
      if (!addsub_y[XLEN+1]) begin
        acc_iter = {addsub_y[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_iter = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_iter = {addsub_y[XLEN:0], acc_q[XLEN-1:1]};
      end else begin
        acc_iter = {1'b0, acc_q[2*XLEN-1:1]};
      end
    end
  end

  // Sign-corrected result of the final iteration, registered when leaving CALC
  always_comb begin
    prod_fix    = neg_q ? -acc_iter : acc_iter;
    quo_fix     = neg_q ? -acc_iter[XLEN-1:0] : acc_iter[XLEN-1:0];
    rem_fix     = neg_q ? -acc_iter[2*XLEN-1:XLEN] : acc_iter[2*XLEN-1:XLEN];
    calc_result = '0;
    case (op_q)
      OP_MUL:                         calc_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   calc_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                calc_result = quo_fix;
      default:                        calc_result = rem_fix;
    endcase
  end

  // Next-state and handshake outputs; flush overrides every transition
  always_comb begin
    state_d          = state_q;
    bus.req_ready_o  = (state_q == ST_IDLE) & ~flush_i;
    bus.resp_valid_o = (state_q == ST_DONE) & ~flush_i;
    bus.result_o     = result_q;
    bus.rd_o         = rd_q;
    busy_o           = (state_q != ST_IDLE);
    accept           = bus.req_valid_i & bus.req_ready_o;
    last_iter        = (state_q == ST_CALC) && (cnt_q == CNT_W'(XLEN - 1));
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (last_iter) state_d = ST_DONE;
      ST_DONE: if (bus.resp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture at accept, iteration in CALC, result latch on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q   <= op_in;
      rd_q   <= bus.rd_i;
      neg_q  <= neg_in;
      acc_q  <= {{XLEN{1'b0}}, mag1};
      opnd_q <= mag2;
      cnt_q  <= '0;
      if (special) result_q <= special_result;
    end else if (state_q == ST_CALC) begin
      acc_q <= acc_iter;
      if (last_iter) begin
        result_q <= calc_result;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
module tb_mdu_iter;
  import core::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic flush_i = 1'b0;
  logic busy_o;

  int checks = 0;
  int passes = 0;

  mdu_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mdu_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Presents a request at the current negedge; returns at the negedge of cycle 1
  task automatic send_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    bus.req_valid_i = 1'b1;
    bus.op_i        = op;
    bus.rs1_i       = a;
    bus.rs2_i       = b;
    bus.rd_i        = tag;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  // Counts cycles after the accept edge until resp_valid; -1 on timeout
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      if (bus.resp_valid_o) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_resp();
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tag_o,
                       output int lat);
    send_req(op, a, b, tag);
    wait_resp(lat);
    res   = bus.result_o;
    tag_o = bus.rd_o;
    if (lat > 0) take_resp();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.resp_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.resp_valid_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); else passes++;
    checks++; if (bus.result_o !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", bus.result_o); else passes++;
    checks++; if (bus.rd_o !== 5'h0) $display("[TB] FAIL reset_rd: got %h expected 00", bus.rd_o); else passes++;
    checks++; if (bus.req_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready_o); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] res; logic [4:0] tag; int lat;
    do_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd4, res, tag, lat);
    checks++; if (res !== 32'hFFFFFFEB) $display("[TB] FAIL mul_neg: got %h expected ffffffeb", res); else passes++;
    checks++; if (lat !== 33) $display("[TB] FAIL mul_latency: got %0d expected 33", lat); else passes++;
    checks++; if (tag !== 5'd4) $display("[TB] FAIL mul_tag: got %0d expected 4", tag); else passes++;
    do_op(OP_MUL, 32'h12345678, 32'h10, 5'd5, res, tag, lat);
    checks++; if (res !== 32'h23456780) $display("[TB] FAIL mul_pos: got %h expected 23456780", res); else passes++;
  endtask

  task automatic test_mulh();
    logic [31:0] res; logic [4:0] tag; int lat;
    do_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, res, tag, lat);
    checks++; if (res !== 32'hFFFFFFFE) $display("[TB] FAIL mulhu: got %h expected fffffffe", res); else passes++;
    do_op(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, res, tag, lat);
    checks++; if (res !== 32'h00000000) $display("[TB] FAIL mulh_m1: got %h expected 00000000", res); else passes++;
    do_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, res, tag, lat);
    checks++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL mulhsu: got %h expected ffffffff", res); else passes++;
    do_op(OP_MULH, 32'h80000000, 32'h80000000, 5'd6, res, tag, lat);
    checks++; if (res !== 32'h40000000) $display("[TB] FAIL mulh_min: got %h expected 40000000", res); else passes++;
  endtask

  task automatic test_special();
    logic [31:0] res; logic [4:0] tag; int lat;
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd7, res, tag, lat);
    checks++; if (res !== 32'h80000000) $display("[TB] FAIL div_ovf: got %h expected 80000000", res); else passes++;
    checks++; if (lat !== 1) $display("[TB] FAIL div_ovf_latency: got %0d expected 1", lat); else passes++;
    do_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd8, res, tag, lat);
    checks++; if (res !== 32'h0) $display("[TB] FAIL rem_ovf: got %h expected 00000000", res); else passes++;
    do_op(OP_REMU, 32'd5, 32'd0, 5'd9, res, tag, lat);
    checks++; if (res !== 32'd5) $display("[TB] FAIL remu_zero: got %h expected 00000005", res); else passes++;
    checks++; if (lat !== 1) $display("[TB] FAIL remu_zero_latency: got %0d expected 1", lat); else passes++;
    do_op(OP_DIVU, 32'd5, 32'd0, 5'd10, res, tag, lat);
    checks++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL divu_zero: got %h expected ffffffff", res); else passes++;
    checks++; if (tag !== 5'd10) $display("[TB] FAIL divu_zero_tag: got %0d expected 10", tag); else passes++;
  endtask

  task automatic test_div();
    logic [31:0] res; logic [4:0] tag; int lat;
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd11, res, tag, lat);
    checks++; if (res !== 32'hFFFFFFFD) $display("[TB] FAIL div_neg: got %h expected fffffffd", res); else passes++;
    checks++; if (lat !== 33) $display("[TB] FAIL div_latency: got %0d expected 33", lat); else passes++;
    do_op(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd12, res, tag, lat);
    checks++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL rem_neg: got %h expected ffffffff", res); else passes++;
    checks++; if (tag !== 5'd12) $display("[TB] FAIL rem_tag: got %0d expected 12", tag); else passes++;
    do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd13, res, tag, lat);
    checks++; if (res !== 32'hFFFFFFFD) $display("[TB] FAIL div_negdivisor: got %h expected fffffffd", res); else passes++;
    do_op(OP_REM, 32'd7, 32'hFFFFFFFE, 5'd14, res, tag, lat);
    checks++; if (res !== 32'd1) $display("[TB] FAIL rem_negdivisor: got %h expected 00000001", res); else passes++;
    do_op(OP_DIVU, 32'd100, 32'd7, 5'd15, res, tag, lat);
    checks++; if (res !== 32'd14) $display("[TB] FAIL divu: got %h expected 0000000e", res); else passes++;
    do_op(OP_REMU, 32'd100, 32'd7, 5'd16, res, tag, lat);
    checks++; if (res !== 32'd2) $display("[TB] FAIL remu: got %h expected 00000002", res); else passes++;
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] tag; int lat;
    send_req(OP_MUL, 32'd3, 32'd3, 5'd17);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 1'b0) $display("[TB] FAIL flush_ready: got %b expected 0", bus.req_ready_o); else passes++;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL flush_busy: got %b expected 0", busy_o); else passes++;
    checks++; if (bus.resp_valid_o !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", bus.resp_valid_o); else passes++;
    do_op(OP_MUL, 32'd6, 32'd9, 5'd18, res, tag, lat);
    checks++; if (res !== 32'd54) $display("[TB] FAIL flush_next_result: got %h expected 00000036", res); else passes++;
    checks++; if (lat !== 33) $display("[TB] FAIL flush_next_latency: got %0d expected 33", lat); else passes++;
    // A request presented together with flush in IDLE is dropped
    bus.req_valid_i = 1'b1;
    bus.op_i = OP_DIVU; bus.rs1_i = 32'd9; bus.rs2_i = 32'd0; bus.rd_i = 5'd19;
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL flush_idle_busy: got %b expected 0", busy_o); else passes++;
    checks++; if (bus.resp_valid_o !== 1'b0) $display("[TB] FAIL flush_idle_valid: got %b expected 0", bus.resp_valid_o); else passes++;
  endtask

  task automatic test_backpressure();
    int lat;
    send_req(OP_DIVU, 32'd100, 32'd7, 5'd20);
    wait_resp(lat);
    checks++; if (lat !== 33) $display("[TB] FAIL bp_latency: got %0d expected 33", lat); else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.resp_valid_o !== 1'b1) $display("[TB] FAIL bp_valid: got %b expected 1", bus.resp_valid_o); else passes++;
      checks++; if (bus.result_o !== 32'd14) $display("[TB] FAIL bp_result: got %h expected 0000000e", bus.result_o); else passes++;
      checks++; if (bus.rd_o !== 5'd20) $display("[TB] FAIL bp_rd: got %0d expected 20", bus.rd_o); else passes++;
      checks++; if (bus.req_ready_o !== 1'b0) $display("[TB] FAIL bp_ready: got %b expected 0", bus.req_ready_o); else passes++;
      @(negedge clk);
    end
    take_resp();
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL bp_after_busy: got %b expected 0", busy_o); else passes++;
    checks++; if (bus.req_ready_o !== 1'b1) $display("[TB] FAIL bp_after_ready: got %b expected 1", bus.req_ready_o); else passes++;
  endtask

  task automatic test_reset_midcalc();
    logic [31:0] res; logic [4:0] tag; int lat;
    send_req(OP_MUL, 32'd5, 32'd5, 5'd21);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.result_o !== 32'h0) $display("[TB] FAIL rst_mid_result: got %h expected 00000000", bus.result_o); else passes++;
    checks++; if (bus.rd_o !== 5'h0) $display("[TB] FAIL rst_mid_rd: got %0d expected 0", bus.rd_o); else passes++;
    checks++; if (bus.resp_valid_o !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %b expected 0", bus.resp_valid_o); else passes++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy_o); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OP_MULHU, 32'h80000000, 32'h4, 5'd22, res, tag, lat);
    checks++; if (res !== 32'h2) $display("[TB] FAIL rst_next_result: got %h expected 00000002", res); else passes++;
    checks++; if (lat !== 33) $display("[TB] FAIL rst_next_latency: got %0d expected 33", lat); else passes++;
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.op_i         = 3'd0;
    bus.rs1_i        = '0;
    bus.rs2_i        = '0;
    bus.rd_i         = '0;
    bus.resp_ready_i = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_special();
    test_div();
    test_flush();
    test_backpressure();
    test_reset_midcalc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL provide parameter TAG_W, default 5, width of destination-register tag.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  kill in-flight operation (pipeline redirect).
REQ-006 req_valid_i  input  1  request present.
REQ-007 req_ready_o  output  1  unit can accept request.
REQ-008 op_i  input  3  RV M-extension funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 rs1_i, rs2_i  input  XLEN each  operands.
REQ-010 rd_i  input  TAG_W  destination tag.
REQ-011 resp_valid_o  output  1  result available.
REQ-012 resp_ready_i  input  1  consumer accepts result.
REQ-013 result_o  output  XLEN  result; rd_o  output  TAG_W  tag of result.
REQ-014 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, CALC, DONE; req_ready_o = (state==IDLE) & ~flush_i.
REQ-016 Accept on req_valid_i & req_ready_o; op, rd, operand magnitudes and result sign captured at acceptance.
REQ-017 Normal op: IDLE -> CALC for exactly XLEN cycles (one bit per cycle, shift-add multiply / restoring divide) -> DONE; resp_valid_o first high XLEN+1 cycles after accept edge.
REQ-018 Special cases skip CALC, IDLE -> DONE, resp_valid_o high 1 cycle after accept: divisor zero (DIV/DIVU -> all ones, REM/REMU -> rs1); signed overflow DIV of 2^(XLEN-1) by -1 (DIV -> 2^(XLEN-1), REM -> 0).
REQ-019 MUL returns low XLEN bits of 2*XLEN product; MULH/MULHSU/MULHU return high XLEN bits with signed×signed, signed×unsigned, unsigned×unsigned interpretation.
REQ-020 DIV/REM truncate toward zero; remainder sign = dividend sign; sign correction applied on the CALC->DONE edge, not combinationally on outputs.
REQ-021 DONE -> IDLE when resp_ready_i; result_o, rd_o, resp_valid_o held stable while resp_valid_o & ~resp_ready_i.
REQ-022 No new request accepted in the DONE cycle (no back-to-back overlap); next accept earliest cycle after handshake.
REQ-023 flush_i has priority over all events: any state -> IDLE next cycle, resp_valid_o low, request presented same cycle not accepted, handshake in same cycle discarded.
REQ-024 Iteration counter width clog2(XLEN)+1; no wrap beyond XLEN.

Reset
REQ-025 rst_n low asynchronously forces state IDLE, counter 0, result_o 0, rd_o 0, resp_valid_o 0, busy_o 0, including mid-CALC.
REQ-026 First accept possible on first clk edge after rst_n deasserts.

Structure
REQ-027 mdu_op_t enum (funct3 encoding) and mdu_state_t SHALL live in shared package core; XLEN default taken from core constant.
REQ-028 One combinational sub-module mdu_special SHALL detect divide-by-zero/overflow and produce the special-case result.
REQ-029 Datapath: one 2*XLEN accumulator/remainder register, one XLEN operand register, shared adder/subtractor.

Verification
REQ-030 MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB, resp_valid_o at cycle 33 after accept.
REQ-031 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1; REMU 5 / 0 -> 5 at cycle 1; DIVU 5 / 0 -> 0xFFFFFFFF.
REQ-033 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF, rd_o equals captured tag.
REQ-034 flush_i at CALC cycle 10 -> IDLE next cycle, no resp_valid_o; new request accepted cycle after.
REQ-035 resp_ready_i low 5 cycles in DONE -> outputs stable, req_ready_o low; rst_n pulse mid-CALC -> all outputs 0 immediately.
